// File: rtl/signed_seq_div.sv
// Signed sequential divider sized for the 7x5 signed multiplier product domain.
// A 12-bit signed dividend is divided by a 5-bit signed divisor using unsigned
// restoring division on the magnitudes, one quotient bit per clock, then sign-fixed
// and saturated to a 7-bit signed quotient.
//
// Ports:
//   clk        clock, rising edge active
//   rst_n      asynchronous active-low reset
//   start      request, accepted only when idle
//   dividend   12-bit two's-complement dividend
//   divisor    5-bit two's-complement divisor
//   busy       high while iterating or fixing signs
//   done       one-cycle pulse when results are updated
//   quotient   7-bit two's-complement quotient (saturated on overflow)
//   remainder  5-bit two's-complement remainder, sign of the dividend
//   ovf        true quotient outside -64..63
//   dbz        divisor was zero
module signed_seq_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] dividend,
    input  logic [4:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [6:0]  quotient,
    output logic [4:0]  remainder,
    output logic        ovf,
    output logic        dbz
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [11:0] acc_q;    // dividend magnitude, shifted out as quotient bits shift in
    logic [5:0]  prem_q;   // partial remainder
    logic [4:0]  dmag_q;
    logic        qneg_q, rneg_q;
    logic        zpend_q;  // zero divisor seen; results are written on the following edge
    logic [6:0]  quotient_q;
    logic [4:0]  remainder_q;
    logic        ovf_q, dbz_q;

    logic [11:0] dvd_mag;
    logic [4:0]  dsr_mag;
    logic [6:0]  trial;
    logic        trial_ge;
    logic [5:0]  trial_diff;
    logic [4:0]  rem_signed;

    assign dvd_mag    = dividend[11] ? (12'd0 - dividend) : dividend;
    assign dsr_mag    = divisor[4] ? (5'd0 - divisor) : divisor;
    assign trial      = {prem_q, acc_q[11]};
    assign trial_ge   = trial >= {2'b00, dmag_q};
    assign trial_diff = trial[5:0] - {1'b0, dmag_q};
    assign rem_signed = rneg_q ? (5'd0 - prem_q[4:0]) : prem_q[4:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (zpend_q) begin
                    state_d = StDone;
                end else if (start && (divisor != 5'd0)) begin
                    state_d = StCalc;
                end
            end
            StCalc:  if (cnt_q == 4'd11) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q == StCalc) || (state_q == StFix);
    assign done = (state_q == StDone);

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            acc_q       <= 12'd0;
            prem_q      <= 6'd0;
            dmag_q      <= 5'd0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            zpend_q     <= 1'b0;
            quotient_q  <= 7'd0;
            remainder_q <= 5'd0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (zpend_q) begin
                        zpend_q     <= 1'b0;
                        quotient_q  <= 7'd0;
                        remainder_q <= 5'd0;
                        ovf_q       <= 1'b0;
                        dbz_q       <= 1'b1;
                    end else if (start) begin
                        acc_q   <= dvd_mag;
                        dmag_q  <= dsr_mag;
                        prem_q  <= 6'd0;
                        cnt_q   <= 4'd0;
                        qneg_q  <= dividend[11] ^ divisor[4];
                        rneg_q  <= dividend[11];
                        zpend_q <= (divisor == 5'd0);
                    end
                end
                StCalc: begin
                    acc_q  <= {acc_q[10:0], trial_ge};
                    prem_q <= trial_ge ? trial_diff : trial[5:0];
                    cnt_q  <= cnt_q + 4'd1;
                end
                StFix: begin
                    remainder_q <= rem_signed;
                    dbz_q       <= 1'b0;
                    if (qneg_q) begin
                        // -64 is representable, so a magnitude of exactly 64 is not overflow
                        if (acc_q > 12'd64) begin
                            quotient_q <= 7'h40;
                            ovf_q      <= 1'b1;
                        end else begin
                            quotient_q <= 7'd0 - acc_q[6:0];
                            ovf_q      <= 1'b0;
                        end
                    end else begin
                        if (acc_q > 12'd63) begin
                            quotient_q <= 7'h3F;
                            ovf_q      <= 1'b1;
                        end else begin
                            quotient_q <= acc_q[6:0];
                            ovf_q      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_signed_seq_div.sv
module tb_signed_seq_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] dividend = 12'd0;
    logic [4:0]  divisor = 5'd0;
    logic        busy, done, ovf, dbz;
    logic [6:0]  quotient;
    logic [4:0]  remainder;

    int compared = 0;
    int mismatched = 0;

    signed_seq_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division from plain integer arithmetic.
    function automatic void ref_div(input logic [11:0] a, input logic [4:0] b,
                                    output logic [6:0] q, output logic [4:0] r,
                                    output logic ovf_e, output logic dbz_e);
        int ai, bi, qt, rt;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) begin
            q = 7'd0; r = 5'd0; ovf_e = 1'b0; dbz_e = 1'b1;
        end else begin
            qt = ai / bi;
            rt = ai % bi;
            r = rt[4:0];
            dbz_e = 1'b0;
            if (qt > 63) begin
                q = 7'h3F; ovf_e = 1'b1;
            end else if (qt < -64) begin
                q = 7'h40; ovf_e = 1'b1;
            end else begin
                q = qt[6:0]; ovf_e = 1'b0;
            end
        end
    endfunction

    // One complete division with latency, result, identity and pulse-width checks.
    task automatic do_div(input logic [11:0] a, input logic [4:0] b);
        logic [6:0] eq;
        logic [4:0] er;
        logic       eovf, edbz;
        int         lat;
        ref_div(a, b, eq, er, eovf, edbz);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operands only need to be stable at the accepting edge
        dividend = 12'($urandom); divisor = 5'($urandom);
        check("busy_after_start", busy, (b != 5'd0) ? 1 : 0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, (b == 5'd0) ? 1 : 13);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("ovf", ovf, eovf);
        check("dbz", dbz, edbz);
        check("busy_in_done", busy, 0);
        if (!eovf && !edbz) begin
            check("identity", $signed(quotient) * $signed(b) + $signed(remainder), $signed(a));
        end
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [6:0] prev_q;
        int         ndone, first_done;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dbz", dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_div(12'd100, 5'd7);
        check("q_100_7", quotient, 7'h0E);
        check("r_100_7", remainder, 5'h02);
        do_div(-12'sd100, 5'd7);
        check("q_m100_7", quotient, 7'h72);
        check("r_m100_7", remainder, 5'h1E);
        do_div(12'd1000, -5'sd16);
        check("q_1000_m16", quotient, 7'h42);
        check("r_1000_m16", remainder, 5'h08);
        do_div(12'd2047, 5'd1);
        check("q_2047_1", quotient, 7'h3F);
        do_div(12'h800, -5'sd16);
        check("q_m2048_m16", quotient, 7'h3F);
        do_div(12'd2047, -5'sd16);
        check("q_2047_m16", quotient, 7'h40);
        do_div(12'h800, 5'd15);
        check("q_m2048_15", quotient, 7'h40);
        do_div(12'd64, -5'sd1);
        do_div(12'd64, 5'd1);
        do_div(12'd0, 5'd5);
        do_div(12'd321, 5'd0);
        do_div(12'd100, 5'd7);

        // Start during a busy operation is ignored; results hold until completion
        prev_q = quotient;
        @(negedge clk);
        dividend = 12'd500; divisor = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_done = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 4) begin
                @(negedge clk);
                dividend = 12'd50; divisor = 5'd9; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 8) check("hold_quotient_midop", quotient, prev_q);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
        end
        check("ignored_start_dones", ndone, 1);
        check("ignored_start_latency", first_done, 13);
        check("ignored_start_q", quotient, 7'h3F);
        check("ignored_start_r", remainder, 5'd2);
        check("ignored_start_ovf", ovf, 1);

        // Reset mid-operation aborts with no done pulse
        @(negedge clk);
        dividend = -12'sd100; divisor = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort_no_activity", ndone, 0);
        do_div(-12'sd100, 5'd7);

        // Randomized operands, with extra weight on the extremes
        for (int i = 0; i < 200; i++) begin
            logic [11:0] a;
            logic [4:0]  b;
            a = 12'($urandom);
            b = 5'($urandom);
            if (i % 10 == 0) a = 12'h800;
            if (i % 10 == 1) a = 12'h7FF;
            if (i % 17 == 0) b = 5'h10;
            do_div(a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
